// File: rtl/stream_arb_mux.sv
// stream_arb_mux: N_CH-channel, W-bit registered stream multiplexer.
// A round-robin arbiter picks one valid input per transfer. The winning beat
// is captured in a single output register with a valid/ready handshake.
// Build option: define STREAM_ARB_FIXED_PRIO_EN to select fixed priority,
// where the lowest valid index always wins. Ports, latency and handshake
// behaviour are the same in both builds.
module stream_arb_mux #(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned W     = 8,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH*W-1:0]   in_data,
  output logic [N_CH-1:0]     in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_sel,
  input  logic                out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [W-1:0]     data_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q;

  logic             load_en;
  logic             gnt_found;
  logic [SEL_W-1:0] gnt_idx;
  logic [W-1:0]     gnt_data;
  logic             xfer;

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  assign load_en = (state_q == EMPTY) || out_ready;
  assign xfer    = gnt_found && load_en && !rst;

  // Grant search: the first pass looks for a valid channel at or above ptr,
  // the second pass (taken only if the first found nothing) wraps to the
  // lowest valid index. This equals a scan in order ptr..ptr+N_CH-1 mod N_CH.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!gnt_found && in_valid[i] && (SEL_W'(i) >= ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = SEL_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!gnt_found && in_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = SEL_W'(i);
      end
    end
  end

  // One-hot ready for the granted channel. It is held low during reset so
  // nothing is acknowledged while rst is asserted.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (xfer && (gnt_idx == SEL_W'(i))) begin
        in_ready[i] = 1'b1;
      end
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data = in_data[i*W +: W];
      end
    end
  end

  // Output register: load on a transfer, drain when the consumer takes the
  // beat and nothing new arrives. Otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else if (xfer) begin
      state_q <= FULL;
      data_q  <= gnt_data;
      sel_q   <= gnt_idx;
    end else if (out_ready) begin
      state_q <= EMPTY;
    end
  end

`ifdef STREAM_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [SEL_W-1:0] ptr_d;

  // Next pointer: the slot after the granted channel, wrapping explicitly so
  // that ptr never exceeds N_CH-1 when N_CH is not a power of two.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Round-robin pointer: it advances only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed, table-driven bench for stream_arb_mux (N_CH=4, W=8).
// Each table row is applied after a clock edge. in_ready is checked before the
// next edge and the registered outputs are checked just after it.
module tb_stream_arb_mux;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  stream_arb_mux #(.N_CH(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] id;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_os;
  } vec_t;

  localparam logic [31:0] DALL = 32'hA3A2A1A0;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   beats_in  = 0;
  int   beats_out = 0;
  int   exp_in    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] iv, input logic [31:0] id, input logic ordy,
                     input logic [3:0] e_rdy, input logic e_ov, input logic [7:0] e_od,
                     input logic [1:0] e_os);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
    vecs.push_back(v);
  endtask

  initial begin
`ifndef STREAM_ARB_FIXED_PRIO_EN
    // Back-to-back round robin over all four channels.
    add(4'hF, DALL, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    add(4'hF, DALL, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
    add(4'hF, DALL, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2);
    add(4'hF, DALL, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3);
    add(4'hF, DALL, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    // Only channel 2 valid, then drain, then the grant order resumes at 3.
    add(4'b0100, 32'hA35CA1A0, 1'b1, 4'b0100, 1'b1, 8'h5C, 2'd2);
    add(4'b0000, DALL, 1'b1, 4'b0000, 1'b0, 8'h5C, 2'd2);
    add(4'hF, DALL, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3);
    // Three-cycle stall while full.
    add(4'hF, DALL, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd3);
    add(4'hF, DALL, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd3);
    add(4'hF, DALL, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd3);
    add(4'hF, DALL, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    // Hold with no input, drain, idle with no rotation.
    add(4'b0000, DALL, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    add(4'b0000, DALL, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0);
    add(4'b0000, DALL, 1'b0, 4'b0000, 1'b0, 8'hA0, 2'd0);
    // Channels 1 and 3: load while empty, stall, then alternate.
    add(4'b1010, DALL, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd1);
    add(4'b1010, DALL, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1);
    add(4'b1010, DALL, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3);
    add(4'b1010, DALL, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
`else
    // Fixed priority: channel 1 always beats channel 3.
    add(4'b1010, DALL, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
    add(4'b1010, DALL, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
    add(4'b1010, DALL, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
    add(4'b1010, DALL, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1);
    add(4'b1000, DALL, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3);
    add(4'hF,    DALL, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
`endif
    foreach (vecs[k]) if (vecs[k].e_rdy != 4'b0000) exp_in++;

    // Reset with live inputs: nothing acknowledged, outputs cleared.
    rst = 1'b1; in_valid = 4'hF; in_data = $urandom; out_ready = 1'b1;
    #3;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_sel",   {30'b0, out_sel}, 32'd0);
    check("rst_out_data",  {24'b0, out_data}, 32'd0);
    check("rst_in_ready",  {28'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("rst_in_ready_edge", {28'b0, in_ready}, 32'd0);
    rst = 1'b0;

    // Table vectors.
    foreach (vecs[k]) begin
      in_valid = vecs[k].iv; in_data = vecs[k].id; out_ready = vecs[k].ordy;
      #1;
      check($sformatf("v%0d_in_ready", k), {28'b0, in_ready}, {28'b0, vecs[k].e_rdy});
      if (|(in_valid & in_ready)) beats_in++;
      if (out_valid && out_ready) beats_out++;
      @(posedge clk); #1;
      check($sformatf("v%0d_out_valid", k), {31'b0, out_valid}, {31'b0, vecs[k].e_ov});
      check($sformatf("v%0d_out_data", k),  {24'b0, out_data},  {24'b0, vecs[k].e_od});
      check($sformatf("v%0d_out_sel", k),   {30'b0, out_sel},   {30'b0, vecs[k].e_os});
    end

    // Drain the final beat and reconcile the scoreboard.
    in_valid = 4'b0000; out_ready = 1'b1;
    #1;
    if (out_valid && out_ready) beats_out++;
    @(posedge clk); #1;
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);
    check("beats_in_expected", beats_in, exp_in);
    check("beats_in_eq_out", beats_in, beats_out);

    // Mid-operation reset: load a beat from channel 0 (ptr moves to 1).
    in_valid = 4'b0001; in_data = DALL; out_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 4'hF;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_in_ready",  {28'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", {28'b0, in_ready}, 32'b0001);
    @(posedge clk); #1;
    check("post_rst_out_sel",   {30'b0, out_sel}, 32'd0);
    check("post_rst_out_data",  {24'b0, out_data}, 32'hA0);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
